// File: rtl/ycbcr444_to_422_pkg.sv
`default_nettype none
// ============================================================================
// Module : ycbcr444_to_422_pkg
// Desc   : Shared video widths, field slices and pixel types for 444->422.
// Rev    : 1.0
// ============================================================================
package ycbcr444_to_422_pkg;

    localparam int Y_W      = 8;
    localparam int C_W      = 8;
    localparam int PIX444_W = 24;
    localparam int PIX422_W = 16;
    localparam int LAT      = 2;

    localparam int Y_HI  = 23;
    localparam int CB_HI = 15;
    localparam int CR_HI = 7;

    typedef enum logic {
        PH_EVEN = 1'b0,
        PH_ODD  = 1'b1
    } phase_e;

    typedef struct packed {
        logic [Y_W-1:0] y;
        logic [C_W-1:0] cb;
        logic [C_W-1:0] cr;
    } pix444_t;

endpackage
`default_nettype wire

// File: rtl/ycbcr444_to_422_chroma_pair_avg.sv
`default_nettype none
// ============================================================================
// Module : chroma_pair_avg
// Desc   : Round-half-up average of two chroma samples, or pass-through of i_a.
// Rev    : 1.0
// ============================================================================
module chroma_pair_avg
    import ycbcr444_to_422_pkg::*;
#(
    parameter bit AVG_EN = 1'b1
)
(
    input  logic [C_W-1:0] i_a,
    input  logic [C_W-1:0] i_b,
    output logic [C_W-1:0] o_c
);

    logic [C_W-1:0] w_avg;

    // (a+b+1)>>1 computed as halves plus a round-up when either LSB is set
    assign w_avg = (i_a >> 1) + (i_b >> 1) + {{(C_W-1){1'b0}}, i_a[0] | i_b[0]};
    assign o_c   = AVG_EN ? w_avg : i_a;

endmodule
`default_nettype wire

// File: rtl/ycbcr444_to_422.sv
`default_nettype none
// ============================================================================
// Module : ycbcr444_to_422
// Desc   : YCbCr444 to YCbCr422 packer with optional chroma averaging and
//          active line width measurement. Fixed 2-cycle latency.
// Rev    : 1.0
// ============================================================================
module ycbcr444_to_422
    import ycbcr444_to_422_pkg::*;
#(
    parameter bit AVG_EN = 1'b1,
    parameter int CNT_W  = 12
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_de,
    input  logic                i_hs,
    input  logic                i_vs,
    input  logic [PIX444_W-1:0] i_data,
    output logic                o_de,
    output logic                o_hs,
    output logic                o_vs,
    output logic [PIX422_W-1:0] o_data,
    output logic [CNT_W-1:0]    line_width,
    output logic                width_vld
);

    pix444_t             w_pix;
    pix444_t             r_s1_pix;
    phase_e              w_phase;
    phase_e              r_s1_phase;
    logic [2:0]          r_sync [LAT];
    logic                w_s1_de;
    logic [C_W-1:0]      w_cb;
    logic [C_W-1:0]      w_cr;
    logic [C_W-1:0]      r_cr_hold;
    logic [PIX422_W-1:0] r_data;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_line_width;
    logic                r_width_vld;
    logic                r_armed;

    always_comb begin
        w_pix    = '0;
        w_pix.y  = i_data[Y_HI  -: Y_W];
        w_pix.cb = i_data[CB_HI -: C_W];
        w_pix.cr = i_data[CR_HI -: C_W];
    end

    assign w_s1_de = r_sync[0][2];

    always_comb begin
        w_phase = PH_EVEN;
        if (i_de && w_s1_de) begin
            w_phase = (r_s1_phase == PH_EVEN) ? PH_ODD : PH_EVEN;
        end
    end

    chroma_pair_avg #(.AVG_EN(AVG_EN)) u_cb_avg (
        .i_a (r_s1_pix.cb),
        .i_b (w_pix.cb),
        .o_c (w_cb)
    );

    chroma_pair_avg #(.AVG_EN(AVG_EN)) u_cr_avg (
        .i_a (r_s1_pix.cr),
        .i_b (w_pix.cr),
        .o_c (w_cr)
    );

    // Stage 1 holds the previous pixel; stage 2 is the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                r_sync[i] <= '0;
            end
            r_s1_pix   <= '0;
            r_s1_phase <= PH_EVEN;
            r_cr_hold  <= '0;
            r_data     <= '0;
        end else begin
            r_sync[0] <= {i_de, i_hs, i_vs};
            for (int i = 1; i < LAT; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_s1_pix   <= w_pix;
            r_s1_phase <= w_phase;
            if (w_s1_de && (r_s1_phase == PH_EVEN)) begin
                if (i_de) begin
                    r_data    <= {r_s1_pix.y, w_cb};
                    r_cr_hold <= w_cr;
                end else begin
                    r_data    <= {r_s1_pix.y, r_s1_pix.cb};
                end
            end else if (w_s1_de) begin
                r_data <= {r_s1_pix.y, r_cr_hold};
            end else begin
                r_data <= '0;
            end
        end
    end

    // Only lines that start after a low i_de cycle out of reset are measured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_armed      <= 1'b0;
            r_line_width <= '0;
            r_width_vld  <= 1'b0;
        end else begin
            r_width_vld <= 1'b0;
            if (!i_de) begin
                r_armed <= 1'b1;
            end
            if (i_de) begin
                if (r_armed && (r_cnt != {CNT_W{1'b1}})) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_s1_de) begin
                if (r_armed) begin
                    r_line_width <= r_cnt;
                    r_width_vld  <= 1'b1;
                end
                r_cnt <= '0;
            end
        end
    end

    assign o_de       = r_sync[LAT-1][2];
    assign o_hs       = r_sync[LAT-1][1];
    assign o_vs       = r_sync[LAT-1][0];
    assign o_data     = r_data;
    assign line_width = r_line_width;
    assign width_vld  = r_width_vld;

endmodule
`default_nettype wire

// File: tb/tb_ycbcr444_to_422.sv
`default_nettype none
// ============================================================================
// Module : tb_ycbcr444_to_422
// Desc   : Self-checking bench; averaging and decimating instances run side by
//          side against a per-line pixel-position reference model.
// Rev    : 1.0
// ============================================================================
module tb_ycbcr444_to_422;

    localparam int N     = 8192;
    localparam int W_MAX = 4095;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        i_de   = 1'b0;
    logic        i_hs   = 1'b0;
    logic        i_vs   = 1'b0;
    logic [23:0] i_data = '0;

    logic [1:0]  o_de_v, o_hs_v, o_vs_v, vld_v;
    logic [15:0] data_v [2];
    logic [11:0] lw_v   [2];

    ycbcr444_to_422 #(.AVG_EN(1'b1), .CNT_W(12)) u_avg (
        .clk(clk), .rst_n(rst_n), .i_de(i_de), .i_hs(i_hs), .i_vs(i_vs),
        .i_data(i_data), .o_de(o_de_v[1]), .o_hs(o_hs_v[1]), .o_vs(o_vs_v[1]),
        .o_data(data_v[1]), .line_width(lw_v[1]), .width_vld(vld_v[1])
    );

    ycbcr444_to_422 #(.AVG_EN(1'b0), .CNT_W(12)) u_dec (
        .clk(clk), .rst_n(rst_n), .i_de(i_de), .i_hs(i_hs), .i_vs(i_vs),
        .i_data(i_data), .o_de(o_de_v[0]), .o_hs(o_hs_v[0]), .o_vs(o_vs_v[0]),
        .o_data(data_v[0]), .line_width(lw_v[0]), .width_vld(vld_v[0])
    );

    always #5 clk = ~clk;

    // Input history and per-cycle position within the active run.
    bit          h_de  [N];
    bit          h_hs  [N];
    bit          h_vs  [N];
    logic [23:0] h_dat [N];
    int          h_pos [N];
    bit          h_ok  [N];
    int          t       = 0;
    int          base    = 0;
    bit          armed_m = 1'b0;
    int          exp_w   = 0;
    bit          exp_vld = 1'b0;
    int          n_chk   = 0;
    int          n_pass  = 0;
    logic [23:0] dq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    function automatic bit D(input int idx);
        return (idx < base) ? 1'b0 : h_de[idx];
    endfunction

    function automatic logic [15:0] exp_data(input int c, input bit avg);
        logic [7:0] y, ch;
        if (!D(c - 1)) return 16'h0000;
        y = h_dat[c-1][23:16];
        if (h_pos[c-1] % 2 == 0) begin
            if (avg && D(c))
                ch = 8'((int'(h_dat[c-1][15:8]) + int'(h_dat[c][15:8]) + 1) / 2);
            else
                ch = h_dat[c-1][15:8];
        end else begin
            if (avg)
                ch = 8'((int'(h_dat[c-2][7:0]) + int'(h_dat[c-1][7:0]) + 1) / 2);
            else
                ch = h_dat[c-2][7:0];
        end
        return {y, ch};
    endfunction

    task automatic check_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_o_de"},   32'(o_de_v[k]), 32'd0);
            chk({tag, "_o_hs"},   32'(o_hs_v[k]), 32'd0);
            chk({tag, "_o_vs"},   32'(o_vs_v[k]), 32'd0);
            chk({tag, "_o_data"}, 32'(data_v[k]), 32'd0);
            chk({tag, "_lw"},     32'(lw_v[k]),   32'd0);
            chk({tag, "_vld"},    32'(vld_v[k]),  32'd0);
        end
    endtask

    task automatic step(input bit de, input bit hs, input bit vs, input logic [23:0] d);
        @(negedge clk);
        i_de = de; i_hs = hs; i_vs = vs; i_data = d;
        h_de[t] = de; h_hs[t] = hs; h_vs[t] = vs; h_dat[t] = d;
        h_pos[t] = de ? (D(t - 1) ? h_pos[t-1] + 1 : 0) : 0;
        h_ok[t]  = de ? (D(t - 1) ? h_ok[t-1] : armed_m) : 1'b0;
        if (!de) armed_m = 1'b1;
        if (D(t - 1) && !de && h_ok[t-1]) begin
            exp_vld = 1'b1;
            exp_w   = (h_pos[t-1] + 1 > W_MAX) ? W_MAX : h_pos[t-1] + 1;
        end else begin
            exp_vld = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk(k ? "avg_o_de"   : "dec_o_de",   32'(o_de_v[k]), 32'(D(t - 1)));
            chk(k ? "avg_o_hs"   : "dec_o_hs",   32'(o_hs_v[k]), 32'((t - 1 >= base) ? h_hs[t-1] : 1'b0));
            chk(k ? "avg_o_vs"   : "dec_o_vs",   32'(o_vs_v[k]), 32'((t - 1 >= base) ? h_vs[t-1] : 1'b0));
            chk(k ? "avg_o_data" : "dec_o_data", 32'(data_v[k]), 32'(exp_data(t, k[0])));
            chk(k ? "avg_vld"    : "dec_vld",    32'(vld_v[k]),  32'(exp_vld));
            chk(k ? "avg_lw"     : "dec_lw",     32'(lw_v[k]),   32'(exp_w));
        end
        t++;
    endtask

    task automatic run_line(input int len, input int blank);
        logic [23:0] d;
        for (int i = 0; i < len; i++) begin
            d = (dq.size() > 0) ? dq.pop_front() : 24'($urandom);
            step(1'b1, 1'($urandom), 1'($urandom), d);
        end
        for (int i = 0; i < blank; i++) begin
            step(1'b0, 1'($urandom), 1'($urandom), 24'($urandom));
        end
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n   = 1'b1;
        base    = t;
        armed_m = 1'b0;
        exp_w   = 0;
        exp_vld = 1'b0;
    endtask

    initial begin
        #23;
        check_zero("reset");
        release_reset();

        run_line(0, 4);

        dq = '{24'h0A64C8, 24'h1465CB, 24'h1E323C, 24'h28333D};
        run_line(4, 3);

        dq = '{24'h0A64C8, 24'h1465CB, 24'h1E323C};
        run_line(3, 3);

        run_line(2, 1);
        run_line(2, 3);

        run_line(3, 0);
        #1;
        rst_n = 1'b0;
        i_de = 1'b0; i_hs = 1'b0; i_vs = 1'b0;
        #1;
        check_zero("midreset");
        release_reset();
        run_line(4, 3);

        run_line(4100, 3);

        for (int l = 0; l < 80; l++) begin
            run_line($urandom_range(0, 9), $urandom_range(1, 4));
        end
        run_line(0, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ycbcr444_to_422.md
Name: ycbcr444_to_422

Overview:
- Converts the scaler's 24-bit YCbCr444 pixel stream into a 16-bit YCbCr422 stream for the output video path and for the scaler line buffers.
- Sits directly after the scaler read path.
- Packs chroma in the same convention the scaler line buffers use on their write side:
  - even pixel carries Cb, odd pixel carries Cr;
  - luma is in the upper byte.
- Optionally averages each horizontal chroma pair, and reports the measured active line width.

Parameters:
AVG_EN, 1, 1 = Cb/Cr of each even/odd pair averaged with round-half-up; 0 = even-pixel Cb and even-pixel Cr sampled, odd-pixel chroma dropped
CNT_W, 12, width of the active-pixel counter and of line_width

Ports:
clk  input  1  pixel clock; single clock domain
rst_n  input  1  asynchronous active-low reset
i_de  input  1  active video enable; high for one contiguous run per line
i_hs  input  1  horizontal sync, passed through
i_vs  input  1  vertical sync, passed through
i_data  input  24  {Y[23:16], Cb[15:8], Cr[7:0]}
o_de  output  1  i_de delayed by LAT
o_hs  output  1  i_hs delayed by LAT
o_vs  output  1  i_vs delayed by LAT
o_data  output  16  {Y[15:8], C[7:0]}; C = Cb on even pixels, Cr on odd pixels
line_width  output  CNT_W  number of i_de-high cycles in the last completed line
width_vld  output  1  one-cycle pulse when line_width updates

Behaviour:
- Reset: all outputs are 0. Pipeline, phase, counters and held chroma are cleared.
- Reset deassertion: the first line starts clean at the next i_de rising edge. A partial line in flight at reset is discarded.
- Latency: LAT = 2 cycles, fixed. o_de, o_hs and o_vs are i_* delayed through exactly 2 registers, regardless of AVG_EN.
- Phase:
  - phase = 0 on the first i_de-high cycle of a line (i_de rising edge).
  - phase toggles on every further i_de-high cycle.
  - phase is forced to 0 whenever i_de is low.
- Pair processing, for a pixel pair at input cycles n (even) and n+1 (odd):
  - Cycle n: register Y0, Cb0, Cr0.
  - Cycle n+1: register Y1. Compute cb = AVG_EN ? (Cb0+Cb1+1)>>1 : Cb0 and cr = AVG_EN ? (Cr0+Cr1+1)>>1 : Cr0. Sums use 9 bits, result is truncated to 8 bits, no saturation needed.
  - Cycle n+2: o_data = {Y0, cb}.
  - Cycle n+3: o_data = {Y1, cr}.
- Odd-length line: the final even pixel at cycle m has no partner, which is detected by i_de low at m+1.
  - Cycle m+2: o_data = {Ym, Cbm}, unaveraged.
  - Its Cr is discarded.
- o_data while o_de is low: 16'h0000. A single zero value is emitted; there is no 8'h80 blanking chroma.
- Width counter:
  - Increments on each i_de-high cycle and saturates at 2^CNT_W-1.
  - On the i_de falling edge: the counter value loads into line_width, width_vld pulses on the next cycle, and the counter clears.
  - A line of length 0 never produces a pulse.
- Simultaneous events: an i_de rising edge on the cycle right after a falling edge (1-cycle blanking) starts a new pair with phase 0. The pending odd-length tail pixel still outputs correctly because its data is held in the stage-2 registers.
- i_hs and i_vs do not affect data processing. They are only delayed.

Decomposition:
- Shared video package holds:
  - localparam Y_W=8, C_W=8, PIX444_W=24, PIX422_W=16, LAT=2;
  - field-slice constants (Y_HI=23, CB_HI=15, CR_HI=7).
- One natural sub-module, chroma_pair_avg: combinational 8+8 round-half-up average with a bypass controlled by AVG_EN. It is instantiated twice, once for Cb and once for Cr.
- The top module holds phase logic, the 2-stage pipeline, the sync delay line and the width counter.

Test Plan:
- Reset, then 4-pixel line, AVG_EN=1. Input (Y,Cb,Cr) = (10,100,200), (20,101,203), (30,50,60), (40,51,61) -> o_data = 0x0A65, 0x14CA, 0x1E33, 0x283D starting 2 cycles after the first i_de. line_width=4 with one width_vld pulse.
- Same stimulus with AVG_EN=0 -> 0x0A64, 0x14C8, 0x1E32, 0x283C.
- 3-pixel line (tail pixel Y=30, Cb=50) -> third output 0x1E32, o_de high for exactly 3 cycles, line_width=3.
- Back-to-back lines with 1-cycle blanking, 2 pixels each -> phase restarts at 0 for line 2, 4 correct outputs, two width_vld pulses each reporting 2.
- rst_n asserted mid-line after 3 pixels -> all outputs 0 immediately. The next full line after release is processed correctly and no width_vld is emitted for the aborted line.
- i_hs/i_vs toggling with i_de low -> o_hs/o_vs exact 2-cycle copies, o_data stays 0, counter does not change.
